// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
// The state and action encodings and the load-use test are common to the RTL and its users.
package pipe_ctrl_pkg;

    localparam int REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] ZERO_REG = 5'd0;

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } hz_state_e;

    // One action per cycle, listed from highest to lowest priority
    typedef enum logic [1:0] {
        ACT_WAIT   = 2'd0,
        ACT_BRANCH = 2'd1,
        ACT_LU     = 2'd2,
        ACT_ADV    = 2'd3
    } hz_action_e;

    function automatic logic load_use(
        input logic                 memread,
        input logic [REG_IDX_W-1:0] ex_rt,
        input logic [REG_IDX_W-1:0] id_rs,
        input logic [REG_IDX_W-1:0] id_rt
    );
        return memread && (ex_rt != ZERO_REG) && ((ex_rt == id_rs) || (ex_rt == id_rt));
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of pipeline hazard inputs, control outputs and event counters.
// master = pipeline datapath side, slave = hazard sequencer.
interface pipeline_hazard_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic                 ex_memread;
    logic [REG_IDX_W-1:0] ex_rt;
    logic [REG_IDX_W-1:0] id_rs;
    logic [REG_IDX_W-1:0] id_rt;
    logic                 ex_branch_taken;
    logic                 mem_req;
    logic                 mem_ready;

    logic                 pc_write;
    logic                 if_id_write;
    logic                 if_id_flush;
    logic                 id_ex_flush;
    logic                 pipe_hold;
    logic                 mem_wb_flush;
    logic [CNT_W-1:0]     lw_stall_cnt;
    logic [CNT_W-1:0]     br_flush_cnt;
    logic [CNT_W-1:0]     mem_wait_cnt;
    logic                 mem_timeout;

    modport master (
        output ex_memread, ex_rt, id_rs, id_rt, ex_branch_taken, mem_req, mem_ready,
        input  pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold, mem_wb_flush,
        input  lw_stall_cnt, br_flush_cnt, mem_wait_cnt, mem_timeout
    );

    modport slave (
        input  ex_memread, ex_rt, id_rs, id_rt, ex_branch_taken, mem_req, mem_ready,
        output pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold, mem_wb_flush,
        output lw_stall_cnt, br_flush_cnt, mem_wait_cnt, mem_timeout
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear, saturating increment, or hold
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = {W{1'b0}};
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard sequencer: per-cycle advance/stall/flush decode for the 5-stage pipeline,
// with saturating event counters and a sticky memory-timeout flag.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    pipeline_hazard_ctrl_if.slave  hz
);

    localparam logic [0:0] RUN      = ST_RUN;
    localparam logic [0:0] MEM_WAIT = ST_MEM_WAIT;

    localparam int               TMO_W     = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(MEM_TIMEOUT - 1);

    logic [0:0]       state_q;
    logic [0:0]       state_d;
    logic             timeout_q;
    logic             timeout_d;

    logic             wait_now_s;
    logic             lu_s;
    hz_action_e       act_s;

    logic             pc_write_s;
    logic             if_id_write_s;
    logic             if_id_flush_s;
    logic             id_ex_flush_s;
    logic             pipe_hold_s;
    logic             mem_wb_flush_s;

    logic [CNT_W-1:0] lw_cnt_s;
    logic [CNT_W-1:0] br_cnt_s;
    logic [CNT_W-1:0] mw_cnt_s;
    logic [TMO_W-1:0] tmo_cnt_s;

    // Hazard detection and priority resolution
    always_comb begin
        wait_now_s = 1'b0;
        if (state_q == MEM_WAIT) begin
            wait_now_s = !hz.mem_ready;
        end else begin
            wait_now_s = hz.mem_req && !hz.mem_ready;
        end

        lu_s = load_use(hz.ex_memread, hz.ex_rt, hz.id_rs, hz.id_rt);

        act_s = ACT_ADV;
        if (wait_now_s) begin
            act_s = ACT_WAIT;
        end else if (hz.ex_branch_taken) begin
            act_s = ACT_BRANCH;
        end else if (lu_s) begin
            act_s = ACT_LU;
        end else begin
            act_s = ACT_ADV;
        end
    end

    // Control decode for the single applied action
    always_comb begin
        pc_write_s     = 1'b1;
        if_id_write_s  = 1'b1;
        if_id_flush_s  = 1'b0;
        id_ex_flush_s  = 1'b0;
        pipe_hold_s    = 1'b0;
        mem_wb_flush_s = 1'b0;
        case (act_s)
            ACT_WAIT: begin
                pc_write_s     = 1'b0;
                if_id_write_s  = 1'b0;
                pipe_hold_s    = 1'b1;
                mem_wb_flush_s = 1'b1;
            end
            ACT_BRANCH: begin
                if_id_flush_s = 1'b1;
                id_ex_flush_s = 1'b1;
            end
            ACT_LU: begin
                pc_write_s    = 1'b0;
                if_id_write_s = 1'b0;
                id_ex_flush_s = 1'b1;
            end
            ACT_ADV: begin
                pc_write_s    = 1'b1;
                if_id_write_s = 1'b1;
            end
            default: begin
                pc_write_s    = 1'b1;
                if_id_write_s = 1'b1;
            end
        endcase
    end

    // FSM next state and sticky timeout; the flag rises at the edge that closes
    // the MEM_TIMEOUT-th consecutive wait cycle, and waiting continues afterwards
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (hz.mem_req && !hz.mem_ready) begin
                    state_d = MEM_WAIT;
                end else begin
                    state_d = RUN;
                end
            end
            MEM_WAIT: begin
                if (hz.mem_ready) begin
                    state_d = RUN;
                end else begin
                    state_d = MEM_WAIT;
                end
            end
            default: state_d = RUN;
        endcase

        timeout_d = timeout_q;
        if (wait_now_s && (tmo_cnt_s >= TMO_LIMIT)) begin
            timeout_d = 1'b1;
        end else begin
            timeout_d = timeout_q;
        end
    end

    // State and flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RUN;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timeout_q <= timeout_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_lw_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (act_s == ACT_LU),
        .clr   (1'b0),
        .cnt_o (lw_cnt_s)
    );

    sat_counter #(.W(CNT_W)) u_br_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (act_s == ACT_BRANCH),
        .clr   (1'b0),
        .cnt_o (br_cnt_s)
    );

    sat_counter #(.W(CNT_W)) u_mw_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (act_s == ACT_WAIT),
        .clr   (1'b0),
        .cnt_o (mw_cnt_s)
    );

    // Consecutive wait cycles; zero whenever not waiting, so it is zero on entry to MEM_WAIT
    sat_counter #(.W(TMO_W)) u_tmo_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (wait_now_s),
        .clr   (!wait_now_s),
        .cnt_o (tmo_cnt_s)
    );

    assign hz.pc_write     = pc_write_s;
    assign hz.if_id_write  = if_id_write_s;
    assign hz.if_id_flush  = if_id_flush_s;
    assign hz.id_ex_flush  = id_ex_flush_s;
    assign hz.pipe_hold    = pipe_hold_s;
    assign hz.mem_wb_flush = mem_wb_flush_s;
    assign hz.lw_stall_cnt = lw_cnt_s;
    assign hz.br_flush_cnt = br_cnt_s;
    assign hz.mem_wait_cnt = mw_cnt_s;
    assign hz.mem_timeout  = timeout_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central hazard sequencer for the 5-stage pipelined processor. Every cycle it decides the pipeline-control actions: advance, stall or flush. The inputs it resolves are load-use hazards between ID and EX, taken-branch squashes resolved in EX, and multi-cycle data-memory waits in MEM. It drives the PC and pipeline-register write enables and flushes, and keeps saturating event counters plus a sticky memory-timeout flag.

## Interface
Parameters:
- `CNT_W`, 16: width of each event counter.
- `MEM_TIMEOUT`, 64: consecutive wait cycles in MEM_WAIT that raise `mem_timeout`.

Ports (clock and reset first):
- `clk`, in, 1: clock, rising edge. One clock domain.
- `rst`, in, 1: reset, asynchronous, active-high.
- `ex_memread`, in, 1: the instruction in EX is a load.
- `ex_rt`, in, 5: destination register of the load in EX.
- `id_rs`, in, 5: source register rs of the instruction in ID.
- `id_rt`, in, 5: source register rt of the instruction in ID.
- `ex_branch_taken`, in, 1: a branch in EX resolved taken.
- `mem_req`, in, 1: MEM stage is accessing data memory this cycle.
- `mem_ready`, in, 1: data memory completes the access this cycle.
- `pc_write`, out, 1: PC update enable.
- `if_id_write`, out, 1: IF/ID register write enable.
- `if_id_flush`, out, 1: zero IF/ID (squash the fetched instruction).
- `id_ex_flush`, out, 1: load a bubble into ID/EX.
- `pipe_hold`, out, 1: freeze ID/EX and EX/MEM.
- `mem_wb_flush`, out, 1: load a bubble into MEM/WB.
- `lw_stall_cnt`, out, CNT_W: count of load-use stall cycles.
- `br_flush_cnt`, out, CNT_W: count of branch flushes.
- `mem_wait_cnt`, out, CNT_W: count of memory wait cycles.
- `mem_timeout`, out, 1: sticky memory-timeout flag.

## Operation
- FSM states: RUN, MEM_WAIT.
- Transitions:
  - RUN to MEM_WAIT when `mem_req && !mem_ready`.
  - MEM_WAIT to RUN when `mem_ready`.
  - Otherwise hold the current state.
- `wait_now` = (RUN && mem_req && !mem_ready) || (MEM_WAIT && !mem_ready).
- `lu` (load-use) = ex_memread && ex_rt != 0 && (ex_rt == id_rs || ex_rt == id_rt). Register 0 never triggers.
- Control outputs are combinational from state and inputs. They resolve with strict priority; only one action applies per cycle:
  1. `wait_now`: pc_write=0, if_id_write=0, pipe_hold=1, mem_wb_flush=1. All other flushes are 0. Branch and load-use are deferred because EX and ID are frozen.
  2. `ex_branch_taken`: if_id_flush=1 and id_ex_flush=1. pc_write=1 and if_id_write=1, so the target is fetched. A simultaneous `lu` is ignored because the ID instruction is squashed.
  3. `lu`: pc_write=0, if_id_write=0, id_ex_flush=1. Exactly one bubble is inserted. The next cycle the load is in MEM, so `lu` clears naturally.
  4. Otherwise (normal advance): pc_write=1, if_id_write=1, all flushes 0, pipe_hold=0.
- Counters saturate at all-ones and never wrap. Each increments by 1 per cycle in which its action is the one applied: priority 3 → `lw_stall_cnt`, 2 → `br_flush_cnt`, 1 → `mem_wait_cnt`.
- Timeout counter:
  - Internal, cleared on entry to MEM_WAIT, incremented each MEM_WAIT cycle.
  - When it reaches MEM_TIMEOUT, `mem_timeout` is set. It clears only on `rst`.
  - The FSM keeps waiting after timeout; there is no forced exit.

## Timing
- Reset values:
  - state=RUN; all counters 0; `mem_timeout`=0.
  - Outputs then follow the RUN decode: pc_write=1, if_id_write=1, flushes 0, pipe_hold=0.
- Reset asserted mid-MEM_WAIT returns to RUN immediately (asynchronously). It clears counters and the flag.
- Latency: control outputs apply in the same cycle as their cause, with zero latency. State, counters and flag update on the next `clk` rising edge.
- Single-cycle access (`mem_req && mem_ready` in RUN): no wait, state stays RUN.
- A branch held in EX during a wait takes effect in the cycle `mem_ready` is seen, because that cycle `wait_now`=0.

## Structure
- Shared package `pipe_ctrl_pkg` holds:
  - the state enum (RUN, MEM_WAIT);
  - the register-index width (5);
  - the zero-register constant.
- One sub-module, `sat_counter`, parameterized by width, with `inc` and `clr` inputs. Instantiate it three times for the event counters and once for the timeout counter.

## Test plan
- Load-use stall: ex_memread=1, ex_rt=5, id_rs=5.
  - Expect pc_write=0, if_id_write=0, id_ex_flush=1 for exactly 1 cycle.
  - Expect lw_stall_cnt 0→1.
  - Repeat with ex_rt=0: no stall.
- Branch with concurrent hazard: ex_branch_taken=1 with the same load-use condition present.
  - Expect if_id_flush=1, id_ex_flush=1, pc_write=1.
  - Expect br_flush_cnt=1 and lw_stall_cnt unchanged.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1.
  - Expect pipe_hold=1 and mem_wb_flush=1 for 3 cycles.
  - Expect mem_wait_cnt=3 and state back to RUN after the ready edge.
- Deferred branch: ex_branch_taken=1 held through a 2-cycle wait.
  - Expect no flush during the wait.
  - Expect the flush in the mem_ready cycle.
- Timeout and reset: MEM_TIMEOUT=4, mem_ready held 0 for 6 cycles.
  - Expect mem_timeout=1 after the 4th wait cycle, with the FSM still in MEM_WAIT.
  - Assert rst asynchronously mid-cycle: expect state RUN, counters 0 and the flag 0 immediately.
- Saturation: CNT_W=2 with 5 load-use stalls.
  - Expect lw_stall_cnt to stick at 3.
